// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: queues 32-bit write-back words in a FIFO and
// streams them out LSB-first as bytes over a valid/ready link.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state;
  logic [31:0]      mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [31:0]      sr;
  logic [1:0]       bi;
  logic             hs;
  logic             pop;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] count_nxt;

  // Valid/ready: a byte transfers on a rising edge where tx_valid and
  // tx_ready are both high; tx_valid/tx_data hold while the consumer stalls.
  assign hs   = (state == SEND) && tx_ready;
  // Pop only looks at registered empty, so a same-cycle push is never seen.
  assign pop  = !empty && ((state == IDLE) || (hs && (bi == 2'd3)));
  assign push = wb_valid && (!full || pop);
  assign drop = wb_valid && full && !pop;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wp] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      state    <= IDLE;
      sr       <= '0;
      bi       <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
      if (drop)
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            sr    <= mem[rp];
            bi    <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (bi != 2'd3) begin
              sr <= {8'h00, sr[31:8]};
              bi <= bi + 1'b1;
            end else if (pop) begin
              sr <= mem[rp];
              bi <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign tx_valid  = (state == SEND);
  assign tx_data   = sr[7:0];
  assign dbg_state = state;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: a byte scoreboard fed at push time and
// drained on every handshake, plus status-flag checks at key points.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             reset;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             dbg_state;

  logic [7:0] exp_q[$];
  int         tests;
  int         fails;

  wb_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: on the falling edge score any byte that will hand off at the
  // coming rising edge, then return just after that rising edge.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    if (!reset && tx_valid && tx_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_byte: observed %0h expected none", tx_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_byte", {24'h0, tx_data}, {24'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic drive_word(input logic [31:0] w);
    wb_valid = 1'b1;
    wb_data  = w;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'h0, (exp_q.size() == 0 && !tx_valid)}, 32'h1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h04040404 + 32'h03020100;
  endfunction

  initial begin
    logic [31:0] w;
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_data  = '0;
    tx_ready = 1'b0;
    do_reset();

    // Reset values
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    check("rst_count",    {27'h0, count},    32'h0);
    check("rst_full",     {31'h0, full},     32'h0);
    check("rst_empty",    {31'h0, empty},    32'h1);
    check("rst_overflow", {31'h0, overflow}, 32'h0);

    // Single word, consumer always ready
    tx_ready = 1'b1;
    push_exp(32'h11223344);
    drive_word(32'h11223344);
    check("single_count_n1", {27'h0, count}, 32'h1);
    check("single_valid_n1", {31'h0, tx_valid}, 32'h0);
    step();
    check("single_valid_n2", {31'h0, tx_valid}, 32'h1);
    check("single_byte0",    {24'h0, tx_data}, 32'h44);
    for (int k = 0; k < 4; k++) step();
    check("single_idle",  {31'h0, tx_valid}, 32'h0);
    check("single_empty", {31'h0, empty}, 32'h1);
    check("single_q",     32'(exp_q.size()), 32'h0);

    // Backpressure: first byte must hold while stalled
    tx_ready = 1'b0;
    push_exp(32'h11223344);
    drive_word(32'h11223344);
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {31'h0, tx_valid}, 32'h1);
      check("bp_hold_data",  {24'h0, tx_data}, 32'h44);
      step();
    end
    tx_ready = 1'b1;
    drain("bp_drain", 20);

    // Overflow: 18 words against a stalled consumer
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i < 17) push_exp(pat(i));
      wb_valid = 1'b1;
      wb_data  = pat(i);
      step();
    end
    wb_valid = 1'b0;
    check("ovf_count",    {27'h0, count}, 32'd16);
    check("ovf_full",     {31'h0, full}, 32'h1);
    check("ovf_flag",     {31'h0, overflow}, 32'h1);
    check("ovf_sr_byte0", {24'h0, tx_data}, {24'h0, pat(0)[7:0]});
    tx_ready = 1'b1;
    drain("ovf_drain", 100);
    check("ovf_sticky", {31'h0, overflow}, 32'h1);
    check("ovf_empty",  {31'h0, empty}, 32'h1);

    // Push accepted while full because the serializer pops the same cycle
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      push_exp(pat(i + 40));
      wb_valid = 1'b1;
      wb_data  = pat(i + 40);
      step();
    end
    wb_valid = 1'b0;
    check("pf_full_before", {31'h0, full}, 32'h1);
    tx_ready = 1'b1;
    step();
    step();
    step();
    push_exp(32'hCAFEF00D);
    drive_word(32'hCAFEF00D);
    check("pf_count",    {27'h0, count}, 32'd16);
    check("pf_full",     {31'h0, full}, 32'h1);
    check("pf_overflow", {31'h0, overflow}, 32'h0);
    drain("pf_drain", 100);

    // Wrap-around: 40 random words, one every 5 cycles
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(32'hFFFF_FFFF, 0);
      push_exp(w);
      drive_word(w);
      for (int k = 0; k < 4; k++) step();
    end
    drain("wrap_drain", 40);
    check("wrap_overflow", {31'h0, overflow}, 32'h0);

    // Reset while byte 2 of a word is on the link, 3 words queued
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(pat(i + 100));
      wb_valid = 1'b1;
      wb_data  = pat(i + 100);
      step();
    end
    wb_valid = 1'b0;
    check("mr_count", {27'h0, count}, 32'd3);
    tx_ready = 1'b1;
    step();
    step();
    check("mr_byte2", {24'h0, tx_data}, {24'h0, pat(100)[23:16]});
    reset = 1'b1;
    step();
    check("mr_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("mr_count0",   {27'h0, count}, 32'h0);
    check("mr_empty",    {31'h0, empty}, 32'h1);
    check("mr_overflow", {31'h0, overflow}, 32'h0);
    reset = 1'b0;
    exp_q.delete();
    push_exp(32'h5A6B7C8D);
    drive_word(32'h5A6B7C8D);
    drain("mr_after_drain", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Captures 32-bit write-back values from the pipeline's write-back stage (the value driven on `salida`) and streams them out as bytes over a valid/ready handshake, toward a host link (UART transmitter or debug port). It sits directly downstream of the pipeline top. A FIFO decouples the one-word-per-cycle write-back rate from a slow byte consumer. Words that arrive while the FIFO is full are dropped, and a sticky flag records the loss.

## Interface
Parameters:
- `DEPTH`, default 16: FIFO depth in 32-bit words; must be a power of 2, at least 2.
- `CNT_W`, default 5: width of `count`; equals $clog2(DEPTH+1).

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wb_valid`  in  1  write-back word present this cycle; the pipeline's `RegWrite` in the WB stage.
- `wb_data`  in  32  write-back value (`salida`).
- `tx_data`  out  8  current output byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  consumer accepts the byte when both `tx_valid` and `tx_ready` are high.
- `count`  out  CNT_W  number of words held in the FIFO (excludes the word in the serializer).
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky: at least one word was dropped since reset.

## Operation
FIFO:
- Circular buffer with write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits wide; both wrap modulo DEPTH.
- Push: `wb_valid && (!full || pop)`. Writes `wb_data` at `wp`, then `wp` increments.
- Pop: asserted by the serializer FSM (below). Reads the word at `rp`, then `rp` increments.
- Simultaneous push and pop: both happen and `count` is unchanged. This holds even when full; a push against a full FIFO that is popped in the same cycle is accepted.
- Drop: `wb_valid && full && !pop`. The word is discarded, `overflow` is set to 1, and it stays 1 until `reset`.

Serializer FSM, states IDLE and SEND:
- Internal state: 32-bit shift register `sr` and 2-bit byte index `bi`.
- IDLE: if `!empty`, pop into `sr`, set `bi=0`, go to SEND. Otherwise stay in IDLE.
- SEND: `tx_valid=1` and `tx_data=sr[7:0]`. Bytes go out LSB first.
- Handshake with `bi<3`: shift `sr` right by 8 and increment `bi`.
- Handshake with `bi==3`: if `!empty`, pop the next word into `sr`, set `bi=0`, and stay in SEND, giving back-to-back words with no gap cycle. Otherwise go to IDLE.
- `tx_data` and `tx_valid` stay stable while `tx_valid && !tx_ready`.
- The pop decision uses the registered `empty`. A word pushed in the same cycle is not visible to the FSM until the next cycle.

Reset:
- Pointers, `count`, `bi` and `sr` clear to 0. FSM goes to IDLE.
- A byte in flight is abandoned and no handshake completes. Reset overrides every push and pop in the same cycle.

## Timing
Reset values: `tx_data=0`, `tx_valid=0`, `count=0`, `full=0`, `empty=1`, `overflow=0`.

Latency:
- If `wb_valid` is high in cycle N with the FIFO empty and the FSM in IDLE, then `count=1` in N+1, the pop happens in N+1, and `tx_valid=1` with byte 0 in N+2.
- With `tx_ready` held high, one word drains in 4 cycles and the stream continues without bubbles.
- Peak sustainable input rate is 1 word per 4 cycles. Faster input fills the FIFO.

Outputs:
- `full`, `empty`, `count` and `overflow` are registered and reflect the state after the last edge.
- `tx_data` and `tx_valid` are registered outputs with no combinational path from `tx_ready`.

Capacity:
- Total storage is DEPTH + 1 words: the FIFO plus the serializer register.

## Test plan
- Single word: after reset, `wb_valid=1`, `wb_data=32'h11223344` for 1 cycle, `tx_ready=1` -> `tx_valid` rises 2 cycles later; bytes 44, 33, 22, 11 on consecutive cycles; then `tx_valid=0`, `empty=1`.
- Backpressure: same word with `tx_ready=0` for 5 cycles, then 1 -> `tx_data=8'h44` held stable the whole time; the sequence then resumes 33, 22, 11 with no byte lost or duplicated.
- Overflow: `tx_ready=0`, push 18 words 0..17 back-to-back (DEPTH=16) -> word 0 sits in the serializer, `count=16`, `full=1`, word 17 dropped, `overflow=1`. Release `tx_ready` -> output words 0..16 in order; `overflow` stays 1.
- Push and pop while full: FIFO full with `tx_ready=1`, and the serializer at `bi==3` pops in the same cycle as a `wb_valid` push -> the push is accepted, `count` stays 16, `overflow` stays 0.
- Wrap-around: stream 40 distinct words at 1 word per 5 cycles -> all 160 bytes come out in order and the pointers wrap correctly.
- Reset mid-operation: assert `reset` during byte 2 of a word with 3 words queued -> next cycle `tx_valid=0`, `count=0`, `empty=1`, `overflow=0`; the next push after that streams normally.
